spi_slv_ctrl: RTL



---
 rtl/spi_slv_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/spi_slv_ctrl.sv
// SPI slave controller: oversamples sclk/ss_n/mosi in the bclk domain, deserializes
// MOSI into words and serializes a buffered transmit word onto MISO.
module spi_slv_ctrl #(
  parameter int DATA_W = 8,
  parameter int CPOL   = 0,
  parameter int CPHA   = 0
) (
  input  logic              bclk,
  input  logic              rstn,
  input  logic              sclk,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              frame_abort
);

  localparam int   CW     = $clog2(DATA_W + 1);
  localparam logic CPOL_B = (CPOL != 0) ? 1'b1 : 1'b0;

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  logic [1:0]        sclk_sync_r, ss_sync_r, mosi_sync_r;
  logic              sclk_d_r;
  state_t            state_r;
  logic [CW-1:0]     bit_cnt_r;
  logic [DATA_W-1:0] tx_shreg_r, rx_shreg_r, buf_r, rx_data_r;
  logic              buf_full_r, rx_valid_r, tx_underrun_r, frame_abort_r;

  logic              sclk_s, ss_s, mosi_s;
  logic              rise_s, fall_s, lead_s, trail_s, sample_s, shift_s;
  logic              ss_fall_s, word_done_s, load_s, accept_s;
  logic [DATA_W-1:0] rx_next_s;

  assign sclk_s  = sclk_sync_r[1];
  assign ss_s    = ss_sync_r[1];
  assign mosi_s  = mosi_sync_r[1];

  assign rise_s   = sclk_s & ~sclk_d_r;
  assign fall_s   = ~sclk_s & sclk_d_r;
  assign lead_s   = CPOL_B ? fall_s : rise_s;
  assign trail_s  = CPOL_B ? rise_s : fall_s;
  assign sample_s = (CPHA == 0) ? lead_s : trail_s;
  assign shift_s  = (CPHA == 0) ? trail_s : lead_s;

  // A select fall wins over any sclk edge seen in the same cycle, since IDLE ignores edges.
  assign ss_fall_s   = (state_r == IDLE) & ~ss_s;
  assign word_done_s = (state_r == ACTIVE) & ~ss_s & sample_s &
                       (bit_cnt_r == CW'(DATA_W - 1));
  assign load_s      = ss_fall_s | word_done_s;
  assign accept_s    = tx_valid & ~buf_full_r;
  assign rx_next_s   = {rx_shreg_r[DATA_W-2:0], mosi_s};

  // Two-flop synchronizers of equal depth plus the sclk edge register.
  always_ff @(posedge bclk or negedge rstn) begin
    if (!rstn) begin
      sclk_sync_r <= {2{CPOL_B}};
      ss_sync_r   <= 2'b11;
      mosi_sync_r <= 2'b00;
      sclk_d_r    <= CPOL_B;
    end else begin
      sclk_sync_r <= {sclk_sync_r[0], sclk};
      ss_sync_r   <= {ss_sync_r[0], ss_n};
      mosi_sync_r <= {mosi_sync_r[0], mosi};
      sclk_d_r    <= sclk_sync_r[1];
    end
  end

  // One-entry transmit holding buffer; an accept can only happen while it is empty.
  always_ff @(posedge bclk or negedge rstn) begin
    if (!rstn) begin
      buf_r      <= {DATA_W{1'b0}};
      buf_full_r <= 1'b0;
    end else if (accept_s) begin
      buf_r      <= tx_data;
      buf_full_r <= 1'b1;
    end else if (load_s && buf_full_r) begin
      buf_full_r <= 1'b0;
    end
  end

  // Frame FSM with bit counter, shift registers and pulsed status outputs.
  always_ff @(posedge bclk or negedge rstn) begin
    if (!rstn) begin
      state_r       <= IDLE;
      bit_cnt_r     <= {CW{1'b0}};
      tx_shreg_r    <= {DATA_W{1'b0}};
      rx_shreg_r    <= {DATA_W{1'b0}};
      rx_data_r     <= {DATA_W{1'b0}};
      rx_valid_r    <= 1'b0;
      tx_underrun_r <= 1'b0;
      frame_abort_r <= 1'b0;
    end else begin
      rx_valid_r    <= 1'b0;
      tx_underrun_r <= 1'b0;
      frame_abort_r <= 1'b0;
      case (state_r)
        IDLE: begin
          bit_cnt_r <= {CW{1'b0}};
          if (!ss_s) begin
            state_r <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (ss_s) begin
            state_r    <= IDLE;
            bit_cnt_r  <= {CW{1'b0}};
            tx_shreg_r <= {DATA_W{1'b0}};
            rx_shreg_r <= {DATA_W{1'b0}};
            if (bit_cnt_r != {CW{1'b0}}) begin
              frame_abort_r <= 1'b1;
            end
          end else if (sample_s) begin
            rx_shreg_r <= rx_next_s;
            if (word_done_s) begin
              bit_cnt_r  <= {CW{1'b0}};
              rx_data_r  <= rx_next_s;
              rx_valid_r <= 1'b1;
            end else begin
              bit_cnt_r <= bit_cnt_r + CW'(1);
            end
          end else if (shift_s && (bit_cnt_r != {CW{1'b0}})) begin
            // The first shift edge of a word is skipped so the MSB stays on the wire.
            tx_shreg_r <= {tx_shreg_r[DATA_W-2:0], 1'b0};
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
      if (load_s) begin
        if (buf_full_r) begin
          tx_shreg_r <= buf_r;
        end else begin
          tx_shreg_r    <= {DATA_W{1'b0}};
          tx_underrun_r <= 1'b1;
        end
      end
    end
  end

  assign miso        = tx_shreg_r[DATA_W-1];
  assign miso_oe     = ~ss_sync_r[1];
  assign tx_ready    = ~buf_full_r;
  assign rx_data     = rx_data_r;
  assign rx_valid    = rx_valid_r;
  assign tx_underrun = tx_underrun_r;
  assign frame_abort = frame_abort_r;

endmodule
